piso_serializer: RTL
====================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: number of bits per parallel word, legal range 2..32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 shifted first, 0 = bit 0 shifted first.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port data_in, input, WIDTH bits: parallel word offered for serialization.
REQ-006 The block SHALL have port load_valid, input, 1 bit: data_in is valid this cycle.
REQ-007 The block SHALL have port load_ready, output, 1 bit: the block accepts data_in this cycle.
REQ-008 The block SHALL have port ser_out, output, 1 bit: serial bit stream to the downstream sequence detector's in.
REQ-009 The block SHALL have port ser_valid, output, 1 bit: ser_out carries a data bit this cycle.
REQ-010 The block SHALL have port busy, output, 1 bit: shift register or holding register occupied.
REQ-011 The block SHALL have port word_done, output, 1 bit: one-cycle pulse in the cycle the last bit of a word is on ser_out.

Function
REQ-012 Storage SHALL be a WIDTH-bit shift register, a WIDTH-bit holding register with full flag, and a bit counter of ceil(log2(WIDTH)) bits.
REQ-013 The FSM SHALL have two states: IDLE (shift register empty) and SHIFT (shift register presenting bits).
REQ-014 The handshake SHALL complete on a rising edge with load_valid=1 and load_ready=1; load_ready SHALL equal NOT holding-full (combinational from registered state only, no dependency on load_valid).
REQ-015 An accepted word in IDLE SHALL go directly to the shift register; the FSM SHALL enter SHIFT with counter=0, and the first bit SHALL appear on ser_out the next cycle (1-cycle latency).
REQ-016 An accepted word in SHIFT SHALL go to the holding register and set holding-full.
REQ-017 In SHIFT, each cycle SHALL present one bit (order per MSB_FIRST), hold ser_valid=1, and increment the counter.
REQ-018 When counter=WIDTH-1, word_done SHALL be 1; on that edge, if holding-full, holding SHALL move to the shift register, holding-full SHALL clear, the counter SHALL become 0, and the FSM SHALL stay in SHIFT (no gap between words); otherwise the FSM SHALL go to IDLE.
REQ-019 Simultaneous events: an accept on the same edge as the last-bit transfer with holding-full=1 is impossible (load_ready=0); with holding-full=0, the accepted word SHALL load the shift register directly and bypass holding.
REQ-020 In IDLE, ser_out SHALL be 1 (line idle high, never forms a 0 for the detector) and ser_valid SHALL be 0.
REQ-021 busy SHALL equal (state==SHIFT) OR holding-full.
REQ-022 data_in SHALL be captured only on accept; changes at other times SHALL have no effect.
REQ-023 Outputs SHALL be registered so ser_out is stable a full cycle, giving the negedge-sampling detector half-cycle setup margin.

Reset
REQ-024 With reset=1 on a rising edge: state=IDLE, counter=0, holding-full=0, shift register=all ones, ser_out=1, ser_valid=0, word_done=0, load_ready=1, busy=0.
REQ-025 Reset SHALL take priority over any accept; a word mid-shift or in holding SHALL be discarded, and no partial bit SHALL follow release.
REQ-026 After reset deasserts, the first accept SHALL be legal on the next edge.

Verification
REQ-027 WIDTH=8, MSB_FIRST=1, accept 8'h36 in IDLE -> ser_out 0,0,1,1,0,1,1,0 on the next 8 cycles, ser_valid=1 throughout, word_done on 8th bit, then IDLE with ser_out=1.
REQ-028 Back-to-back: accept 8'hA5, then 8'h3C while shifting -> load_ready drops to 0, 16 contiguous valid bits with no gap, word_done pulses at bits 8 and 16.
REQ-029 Third word offered while holding is full -> load_ready=0 and the word is not taken; it is taken on the edge after the first word finishes, and the stream stays gapless.
REQ-030 MSB_FIRST=0, accept 8'h01 -> ser_out 1,0,0,0,0,0,0,0.
REQ-031 Assert reset at bit 4 of a word with holding full -> next cycle ser_valid=0, ser_out=1, busy=0, load_ready=1, no remaining bits emitted.
REQ-032 Feed the 8'h36 stream into the 0110 detector -> detector out asserts on each 0110 boundary, and the idle-high line causes no false detection.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out converter with a one-word holding register so that
// consecutive words stream out without a gap. The line idles high.
module piso_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output logic             word_done
);

   localparam int              CW      = $clog2(WIDTH);
   localparam int              OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;
   localparam logic [CW-1:0]   LAST    = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state, state_n;
   logic [CW-1:0]    count, count_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [WIDTH-1:0] hold, hold_n;
   logic             full, full_n;
   logic             done, done_n;
   logic [WIDTH-1:0] shifted;
   logic             accept;
   logic             last;

   // Shift towards the output end, back-filling with ones so an idle line stays high.
   assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b1} : {1'b1, shreg[WIDTH-1:1]};

   assign load_ready = ~full;
   assign accept     = load_valid & ~full;
   assign last       = (state == SHIFT) && (count == LAST);

   // Outputs come straight from flops: the presenting shift-register bit,
   // the state bit and a precomputed last-bit flag.
   assign ser_out    = shreg[OUT_IDX];
   assign ser_valid  = (state == SHIFT);
   assign busy       = (state == SHIFT) | full;
   assign word_done  = done;

   // Next-state, datapath and holding-register control.
   always_comb begin
      state_n = state;
      count_n = count;
      shreg_n = shreg;
      hold_n  = hold;
      full_n  = full;
      case (state)
         IDLE: begin
            if (accept) begin
               shreg_n = data_in;
               count_n = '0;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            if (last) begin
               if (full) begin
                  shreg_n = hold;
                  full_n  = 1'b0;
                  count_n = '0;
               end else if (accept) begin
                  // Word arriving on the last-bit edge bypasses the holding register.
                  shreg_n = data_in;
                  count_n = '0;
               end else begin
                  shreg_n = '1;
                  count_n = '0;
                  state_n = IDLE;
               end
            end else begin
               shreg_n = shifted;
               count_n = count + 1'b1;
               if (accept) begin
                  hold_n = data_in;
                  full_n = 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            shreg_n = '1;
            count_n = '0;
            full_n  = 1'b0;
         end
      endcase
      done_n = (state_n == SHIFT) && (count_n == LAST);
   end

   // State and datapath registers; reset discards any word in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         shreg <= '1;
         hold  <= '0;
         full  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         count <= count_n;
         shreg <= shreg_n;
         hold  <= hold_n;
         full  <= full_n;
         done  <= done_n;
      end
   end

endmodule
